inst_fetch_ctrl: RTL and testbench
==================================

Name: inst_fetch_ctrl

Overview:
- Responder side of the instruction-fetch interface. Accepts the fetch address and chip-enable produced by the PC register.
- Performs a multi-cycle read of the external instruction SRAM with a programmable number of wait states.
- Returns the 32-bit instruction to the IF/ID stage.
- Raises a stall request back to the pipeline controller until the word is available.

Parameters:
- WAIT_CYCLES, 2, SRAM access cycles per fetch (legal range 1..15).
- ADDR_W, 20, SRAM word-address width.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- ce_i  input  1  fetch enable from PC register
- pc_i  input  32  fetch byte address
- flush_i  input  1  pipeline flush; aborts or squashes the current fetch
- inst_o  output  32  fetched instruction
- inst_valid_o  output  1  inst_o is valid this cycle
- stallreq_o  output  1  request to stall the fetch stage
- sram_addr_o  output  ADDR_W  SRAM word address
- sram_ce_n_o  output  1  SRAM chip enable, active-low
- sram_oe_n_o  output  1  SRAM output enable, active-low
- sram_data_i  input  32  SRAM read data

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-read):
  - state=IDLE, counter=0, latched address=0.
  - inst_o=0, inst_valid_o=0, stallreq_o=0.
  - sram_ce_n_o=1, sram_oe_n_o=1, sram_addr_o=0.
- States: IDLE, READ, DONE.
- IDLE:
  - If ce_i=1 and flush_i=0: latch pc_i[ADDR_W+1:2] into the address register, clear the counter, go to READ.
  - stallreq_o=1 combinationally in this accept cycle.
  - If ce_i=0 or flush_i=1: stay in IDLE, stallreq_o=0.
- READ:
  - sram_ce_n_o=0, sram_oe_n_o=0, sram_addr_o=latched address (registered; stable for the whole access).
  - stallreq_o=1.
  - Counter increments each cycle. On the cycle with counter==WAIT_CYCLES-1, capture sram_data_i into inst_o at the clock edge and go to DONE.
- DONE:
  - SRAM controls deasserted (ce_n=1, oe_n=1).
  - stallreq_o=0.
  - inst_valid_o = ~flush_i (combinational).
  - Always go to IDLE next cycle.
- Latency: request accepted at cycle T → stallreq_o high T..T+WAIT_CYCLES → inst_valid_o high at T+WAIT_CYCLES+1 for exactly one cycle.
- Throughput: one instruction per WAIT_CYCLES+2 cycles.
- The PC register advances on the DONE edge, because stallreq_o is low in DONE.
- pc_i[1:0] are ignored: word read. Address bits above ADDR_W+1 are ignored.
- ce_i falling during READ: the access completes normally and inst_valid_o still asserts in DONE.
- pc_i changing during READ: ignored; the latched address is used.
- flush_i during READ:
  - Next state is IDLE.
  - inst_o is not updated, no inst_valid_o pulse.
  - stallreq_o=0 in the flush cycle.
  - SRAM controls deassert on the next cycle.
- flush_i during IDLE with ce_i=1: the request is not accepted. It is accepted the first cycle flush_i=0.
- inst_o holds its last captured value until the next completed read; it changes only on a DONE entry.
- Counter width is 4 bits. No wrap is possible within the legal WAIT_CYCLES range.

Test Plan:
1. Basic fetch: WAIT_CYCLES=2, ce_i=1, pc_i=0x80000004, sram_data_i=0x24020005 → sram_addr_o=0x00001 with ce_n/oe_n low for 2 cycles; stallreq_o high 3 cycles; inst_valid_o=1 for one cycle with inst_o=0x24020005; returns to IDLE.
2. Back-to-back: pc_i 0x0→0x4→0x8 with data 0x11111111/0x22222222/0x33333333 → three valid pulses 4 cycles apart, in order, with correct data and addresses 0x0/0x1/0x2.
3. Flush mid-read: flush_i=1 in the second READ cycle → no valid pulse; inst_o keeps its previous value; stallreq_o low the same cycle; SRAM controls high the next cycle.
4. Idle/disable: ce_i=0 for 10 cycles → stallreq_o=0, inst_valid_o=0, sram_ce_n_o=1 throughout; ce_i dropped during READ → the access still completes with valid=1.
5. Asynchronous reset mid-read: rst pulsed between clock edges during READ → outputs go to reset values immediately (before the next edge); after release with ce_i=1, a new fetch starts cleanly.
6. Parameter sweep: WAIT_CYCLES=1 and 15 → stallreq_o high for 2 and 16 cycles respectively; correct data is captured on the final READ cycle.

Source files
------------

// File: rtl/inst_fetch_ctrl_if.sv
// Fetch-side handshake and external SRAM read bus for the instruction fetch controller.
interface inst_fetch_ctrl_if #(
  parameter int ADDR_W = 20
);
  logic              ce_i;
  logic [31:0]       pc_i;
  logic              flush_i;
  logic [31:0]       inst_o;
  logic              inst_valid_o;
  logic              stallreq_o;
  logic [ADDR_W-1:0] sram_addr_o;
  logic              sram_ce_n_o;
  logic              sram_oe_n_o;
  logic [31:0]       sram_data_i;

  modport slave (
    input  ce_i, pc_i, flush_i, sram_data_i,
    output inst_o, inst_valid_o, stallreq_o, sram_addr_o, sram_ce_n_o, sram_oe_n_o
  );

  modport master (
    output ce_i, pc_i, flush_i, sram_data_i,
    input  inst_o, inst_valid_o, stallreq_o, sram_addr_o, sram_ce_n_o, sram_oe_n_o
  );
endinterface

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: multi-cycle SRAM word read with programmable wait states,
// stall request to the pipeline until the instruction word is available.
module inst_fetch_ctrl #(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 20
) (
  input logic              clk,
  input logic              rst,
  inst_fetch_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_e            state_r;
  state_e            state_nxt_s;
  logic [3:0]        cnt_r;
  logic [3:0]        cnt_nxt_s;
  logic              accept_s;
  logic              capture_s;
  logic              stall_s;
  logic              valid_s;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       inst_r;
  logic              sram_en_n_r;
  logic              unused_pc_s;

  // Byte-offset and out-of-range address bits take no part in the word address.
  assign unused_pc_s = ^{bus.pc_i[31:ADDR_W+2], bus.pc_i[1:0]};

  // Next-state, counter and handshake decode.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    accept_s    = 1'b0;
    capture_s   = 1'b0;
    stall_s     = 1'b0;
    valid_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // No stall is raised while reset is held, even with a pending request.
        if (bus.ce_i && !bus.flush_i && !rst) begin
          accept_s    = 1'b1;
          stall_s     = 1'b1;
          cnt_nxt_s   = 4'd0;
          state_nxt_s = ST_READ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_READ: begin
        if (bus.flush_i) begin
          state_nxt_s = ST_IDLE;
        end else if (cnt_r == LAST_CNT) begin
          stall_s     = 1'b1;
          capture_s   = 1'b1;
          state_nxt_s = ST_DONE;
        end else begin
          stall_s     = 1'b1;
          cnt_nxt_s   = cnt_r + 4'd1;
        end
      end
      ST_DONE: begin
        valid_s     = ~bus.flush_i;
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State and wait-state counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Address latch, instruction capture and SRAM strobes; strobes are low exactly while in READ.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_r      <= {ADDR_W{1'b0}};
      inst_r      <= 32'd0;
      sram_en_n_r <= 1'b1;
    end else begin
      if (accept_s) begin
        addr_r <= bus.pc_i[ADDR_W+1:2];
      end
      if (capture_s) begin
        inst_r <= bus.sram_data_i;
      end
      sram_en_n_r <= (state_nxt_s != ST_READ);
    end
  end

  assign bus.inst_o       = inst_r;
  assign bus.inst_valid_o = valid_s;
  assign bus.stallreq_o   = stall_s;
  assign bus.sram_addr_o  = addr_r;
  assign bus.sram_ce_n_o  = sram_en_n_r;
  assign bus.sram_oe_n_o  = sram_en_n_r;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed self-checking bench for inst_fetch_ctrl (WAIT_CYCLES 2, 1 and 15 instances).
module tb_inst_fetch_ctrl;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  inst_fetch_ctrl_if #(.ADDR_W(20)) bus2 ();
  inst_fetch_ctrl_if #(.ADDR_W(20)) bus1 ();
  inst_fetch_ctrl_if #(.ADDR_W(20)) bus15 ();

  inst_fetch_ctrl #(.WAIT_CYCLES(2),  .ADDR_W(20)) dut2  (.clk(clk), .rst(rst), .bus(bus2.slave));
  inst_fetch_ctrl #(.WAIT_CYCLES(1),  .ADDR_W(20)) dut1  (.clk(clk), .rst(rst), .bus(bus1.slave));
  inst_fetch_ctrl #(.WAIT_CYCLES(15), .ADDR_W(20)) dut15 (.clk(clk), .rst(rst), .bus(bus15.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge, drive the W=2 inputs, let them settle.
  task automatic step2(input logic ce, input logic [31:0] pc, input logic fl, input logic [31:0] d);
    @(posedge clk);
    #1;
    bus2.ce_i        = ce;
    bus2.pc_i        = pc;
    bus2.flush_i     = fl;
    bus2.sram_data_i = d;
    #1;
  endtask

  logic [31:0] pat [3];
  logic [31:0] good1;
  logic [31:0] good15;
  logic [31:0] bad;

  initial begin
    n_cmp = 0;
    n_err = 0;
    pat[0] = 32'h1111_1111;
    pat[1] = 32'h2222_2222;
    pat[2] = 32'h3333_3333;
    good1  = 32'h0101_0101;
    good15 = 32'h1515_1515;
    bad    = 32'hBAD0_BAD0;
    rst = 1'b1;
    bus2.ce_i = 1'b0;  bus2.pc_i = 32'd0;  bus2.flush_i = 1'b0;  bus2.sram_data_i = 32'd0;
    bus1.ce_i = 1'b0;  bus1.pc_i = 32'd0;  bus1.flush_i = 1'b0;  bus1.sram_data_i = 32'd0;
    bus15.ce_i = 1'b0; bus15.pc_i = 32'd0; bus15.flush_i = 1'b0; bus15.sram_data_i = 32'd0;

    // Reset state
    #2;
    chk("rst_inst",  bus2.inst_o, 32'd0);
    chk("rst_valid", 32'(bus2.inst_valid_o), 32'd0);
    chk("rst_stall", 32'(bus2.stallreq_o), 32'd0);
    chk("rst_ce_n",  32'(bus2.sram_ce_n_o), 32'd1);
    chk("rst_oe_n",  32'(bus2.sram_oe_n_o), 32'd1);
    chk("rst_addr",  32'(bus2.sram_addr_o), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 1. Basic fetch at 0x80000004
    step2(1'b1, 32'h8000_0004, 1'b0, 32'h2402_0005);
    chk("t1_acc_stall", 32'(bus2.stallreq_o), 32'd1);
    chk("t1_acc_ce_n",  32'(bus2.sram_ce_n_o), 32'd1);
    for (int c = 0; c < 2; c++) begin
      step2(1'b1, 32'h8000_0004, 1'b0, 32'h2402_0005);
      chk("t1_rd_addr",  32'(bus2.sram_addr_o), 32'h0000_0001);
      chk("t1_rd_ce_n",  32'(bus2.sram_ce_n_o), 32'd0);
      chk("t1_rd_oe_n",  32'(bus2.sram_oe_n_o), 32'd0);
      chk("t1_rd_stall", 32'(bus2.stallreq_o), 32'd1);
      chk("t1_rd_valid", 32'(bus2.inst_valid_o), 32'd0);
    end
    step2(1'b0, 32'h8000_0004, 1'b0, 32'h2402_0005);
    chk("t1_done_valid", 32'(bus2.inst_valid_o), 32'd1);
    chk("t1_done_inst",  bus2.inst_o, 32'h2402_0005);
    chk("t1_done_stall", 32'(bus2.stallreq_o), 32'd0);
    chk("t1_done_ce_n",  32'(bus2.sram_ce_n_o), 32'd1);
    step2(1'b0, 32'h0, 1'b0, 32'h0);
    chk("t1_idle_valid", 32'(bus2.inst_valid_o), 32'd0);
    chk("t1_idle_inst",  bus2.inst_o, 32'h2402_0005);

    // 2. Back-to-back fetches, one valid pulse every 4 cycles
    for (int k = 0; k < 3; k++) begin
      step2(1'b1, 32'(4 * k), 1'b0, pat[k]);
      chk("t2_acc_stall", 32'(bus2.stallreq_o), 32'd1);
      chk("t2_acc_valid", 32'(bus2.inst_valid_o), 32'd0);
      for (int c = 0; c < 2; c++) begin
        step2(1'b1, 32'(4 * k), 1'b0, pat[k]);
        chk("t2_rd_addr",  32'(bus2.sram_addr_o), 32'(k));
        chk("t2_rd_ce_n",  32'(bus2.sram_ce_n_o), 32'd0);
        chk("t2_rd_valid", 32'(bus2.inst_valid_o), 32'd0);
      end
      step2((k == 2) ? 1'b0 : 1'b1, 32'(4 * k + 4), 1'b0, pat[k]);
      chk("t2_done_valid", 32'(bus2.inst_valid_o), 32'd1);
      chk("t2_done_inst",  bus2.inst_o, pat[k]);
      chk("t2_done_stall", 32'(bus2.stallreq_o), 32'd0);
    end

    // 3. Flush in the second READ cycle
    step2(1'b1, 32'h10, 1'b0, 32'hDEAD_BEEF);
    chk("t3_acc_stall", 32'(bus2.stallreq_o), 32'd1);
    step2(1'b1, 32'h10, 1'b0, 32'hDEAD_BEEF);
    chk("t3_rd_ce_n", 32'(bus2.sram_ce_n_o), 32'd0);
    step2(1'b0, 32'h10, 1'b1, 32'hDEAD_BEEF);
    chk("t3_fl_stall", 32'(bus2.stallreq_o), 32'd0);
    chk("t3_fl_valid", 32'(bus2.inst_valid_o), 32'd0);
    chk("t3_fl_ce_n",  32'(bus2.sram_ce_n_o), 32'd0);
    step2(1'b0, 32'h10, 1'b0, 32'hDEAD_BEEF);
    chk("t3_post_ce_n",  32'(bus2.sram_ce_n_o), 32'd1);
    chk("t3_post_oe_n",  32'(bus2.sram_oe_n_o), 32'd1);
    chk("t3_post_valid", 32'(bus2.inst_valid_o), 32'd0);
    chk("t3_post_inst",  bus2.inst_o, 32'h3333_3333);

    // Flush while idle blocks acceptance; ce dropped mid-read still completes
    step2(1'b1, 32'h20, 1'b1, 32'hCAFE_F00D);
    chk("t3_idlefl_stall", 32'(bus2.stallreq_o), 32'd0);
    step2(1'b1, 32'h20, 1'b0, 32'hCAFE_F00D);
    chk("t3_acc2_stall", 32'(bus2.stallreq_o), 32'd1);
    step2(1'b0, 32'h20, 1'b0, 32'hCAFE_F00D);
    chk("t4_cedrop_addr",  32'(bus2.sram_addr_o), 32'h8);
    chk("t4_cedrop_stall", 32'(bus2.stallreq_o), 32'd1);
    step2(1'b0, 32'h20, 1'b0, 32'hCAFE_F00D);
    chk("t4_cedrop_ce_n", 32'(bus2.sram_ce_n_o), 32'd0);
    step2(1'b0, 32'h20, 1'b0, 32'hCAFE_F00D);
    chk("t4_cedrop_valid", 32'(bus2.inst_valid_o), 32'd1);
    chk("t4_cedrop_inst",  bus2.inst_o, 32'hCAFE_F00D);

    // 4. Idle with ce low for 10 cycles
    for (int c = 0; c < 10; c++) begin
      step2(1'b0, 32'h44, 1'b0, 32'h0);
      chk("t4_idle_stall", 32'(bus2.stallreq_o), 32'd0);
      chk("t4_idle_valid", 32'(bus2.inst_valid_o), 32'd0);
      chk("t4_idle_ce_n",  32'(bus2.sram_ce_n_o), 32'd1);
    end

    // 5. Asynchronous reset between edges during READ
    step2(1'b1, 32'h40, 1'b0, 32'h55AA_55AA);
    step2(1'b1, 32'h40, 1'b0, 32'h55AA_55AA);
    chk("t5_pre_ce_n", 32'(bus2.sram_ce_n_o), 32'd0);
    rst = 1'b1;
    #1;
    chk("t5_rst_ce_n",  32'(bus2.sram_ce_n_o), 32'd1);
    chk("t5_rst_oe_n",  32'(bus2.sram_oe_n_o), 32'd1);
    chk("t5_rst_addr",  32'(bus2.sram_addr_o), 32'd0);
    chk("t5_rst_stall", 32'(bus2.stallreq_o), 32'd0);
    chk("t5_rst_valid", 32'(bus2.inst_valid_o), 32'd0);
    chk("t5_rst_inst",  bus2.inst_o, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("t5_acc_stall", 32'(bus2.stallreq_o), 32'd1);
    step2(1'b1, 32'h40, 1'b0, 32'h55AA_55AA);
    chk("t5_rd_addr", 32'(bus2.sram_addr_o), 32'h10);
    step2(1'b1, 32'h40, 1'b0, 32'h55AA_55AA);
    chk("t5_rd_ce_n", 32'(bus2.sram_ce_n_o), 32'd0);
    step2(1'b0, 32'h40, 1'b0, 32'h55AA_55AA);
    chk("t5_done_valid", 32'(bus2.inst_valid_o), 32'd1);
    chk("t5_done_inst",  bus2.inst_o, 32'h55AA_55AA);

    // 6. WAIT_CYCLES = 1 and 15; good data only on each final READ cycle
    for (int i = 0; i < 18; i++) begin
      @(posedge clk);
      #1;
      bus1.ce_i         = (i == 0);
      bus1.pc_i         = 32'h100;
      bus1.sram_data_i  = (i == 1) ? good1 : bad;
      bus15.ce_i        = (i == 0);
      bus15.pc_i        = 32'h200;
      bus15.sram_data_i = (i == 15) ? good15 : bad;
      #1;
      chk("t6_w1_stall",  32'(bus1.stallreq_o), 32'(i <= 1));
      chk("t6_w1_valid",  32'(bus1.inst_valid_o), 32'(i == 2));
      chk("t6_w15_stall", 32'(bus15.stallreq_o), 32'(i <= 15));
      chk("t6_w15_valid", 32'(bus15.inst_valid_o), 32'(i == 16));
      chk("t6_w15_ce_n",  32'(bus15.sram_ce_n_o), 32'(!(i >= 1 && i <= 15)));
      if (i == 2) begin
        chk("t6_w1_inst", bus1.inst_o, good1);
        chk("t6_w1_addr", 32'(bus1.sram_addr_o), 32'h40);
      end else if (i == 16) begin
        chk("t6_w15_inst", bus15.inst_o, good15);
        chk("t6_w15_addr", 32'(bus15.sram_addr_o), 32'h80);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
